generic_serializer: RTL
=======================

Name: generic_serializer

Overview:
- Transmit side of the 32-bit generic flit link. Accepts one parallel TileLink-style flit: chanId, opcode, param, size, source, address, data, corrupt, union.
- Packs the flit into a 192-bit frame and emits it as 6 beats of 32 bits, lowest word first, over a valid/ready stream.
- Feeds the matching generic deserializer at the far end of the link, which reassembles the identical field layout.

Parameters:
- W, 32, beat width in bits; ports are sized for this value.
- BEATS, 6, beats per flit; BEATS*W must be at least 164.

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- io_in_valid  in  1  flit offered
- io_in_ready  out  1  flit accepted when valid&ready
- io_in_bits_chanId  in  3  channel id
- io_in_bits_opcode  in  3  opcode
- io_in_bits_param  in  3  param
- io_in_bits_size  in  8  size
- io_in_bits_source  in  8  source id
- io_in_bits_address  in  64  address
- io_in_bits_data  in  64  data
- io_in_bits_corrupt  in  1  corrupt flag
- io_in_bits_union  in  9  mask/union field
- io_out_valid  out  1  beat valid
- io_out_ready  in  1  beat accepted when valid&ready
- io_out_bits  out  32  current beat

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Frame layout (192 bits, beat k = frame[32k+31:32k]):
  - [0] = 0
  - union [9:1], corrupt [10], data [74:11], address [138:75]
  - source [146:139], size [154:147], param [157:155], opcode [160:158], chanId [163:161]
  - [191:164] = 0
- State: 1-bit sending; 3-bit sendCount; BEATS x W data registers.
- Reset: sending=0, sendCount=0, io_in_ready=1, io_out_valid=0. Data registers are not reset.
- Idle (sending=0):
  - io_in_ready=1, io_out_valid=0.
  - On in fire: capture the packed frame, set sending=1, sendCount=0.
  - First beat appears the next cycle (1-cycle latency).
- Sending (sending=1):
  - io_in_ready=0 (base build), io_out_valid=1, io_out_bits = data[sendCount].
  - On out fire with sendCount<5: sendCount+1.
  - On out fire with sendCount==5: sendCount=0, sending=0.
- Stall: io_out_ready=0 holds io_out_bits and sendCount stable. io_out_valid never drops once raised until the beat fires.
- io_out_bits is driven only from registers; no combinational path from io_in_bits to io_out_bits.
- Back-to-back (base build): one idle cycle between the last beat of flit N and acceptance of flit N+1. Peak throughput is 1 flit per 7 cycles.
- Reset mid-frame: the frame is abandoned; state returns to idle the next cycle; no partial beats resume.
- Captured frame is immutable while sending; changes on io_in_bits are ignored.

Optional Feature:
- Macro: GENERIC_SERIALIZER_BACK_TO_BACK_EN.
- Defined:
  - io_in_ready = ~sending | (io_out_ready & sendCount==5).
  - A flit accepted in the same cycle as the last-beat fire loads the registers, keeps sending=1 and sets sendCount=0.
  - Throughput is 1 flit per 6 cycles.
- Undefined: base behaviour, io_in_ready = ~sending.

Decomposition:
- Package generic_flit_pkg holds:
  - field width constants (CHANID_W=3, OPCODE_W=3, PARAM_W=3, SIZE_W=8, SOURCE_W=8, ADDR_W=64, DATA_W=64, UNION_W=9)
  - per-field LSB offset constants per the layout above
  - FLIT_BITS=164, BEATS=6, BEAT_W=32
  - a packed struct typedef generic_flit_t
  - a pack function returning the 192-bit frame
- The deserializer reuses the same package so both ends share one layout.
- No sub-module; pack logic is a package function and the FSM stays in generic_serializer.

Test Plan:
- Reset, then one flit (chanId=3'h5, opcode=3'h4, param=3'h2, size=8'h06, source=8'hA5, address=64'h0123456789ABCDEF, data=64'hFEDCBA9876543210, corrupt=1, union=9'h1FF) with io_out_ready=1 -> exactly 6 beats on consecutive cycles starting 1 cycle after accept. Beats match the package pack function; beat5[3:1]=3'h5 and beat5[31:4]=0.
- Loopback through generic_deserializer with 1000 random flits and random valid/ready -> every output field equals its input field, in order.
- Hold io_out_ready=0 for 10 cycles mid-frame (sendCount=2), then release -> io_out_valid stays 1, io_out_bits is constant, beats 2..5 follow with no loss or duplication.
- io_in_valid held continuously, io_out_ready=1 -> flits accepted every 7 cycles in the base build, every 6 cycles with GENERIC_SERIALIZER_BACK_TO_BACK_EN; io_in_ready=0 during beats 0..4.
- Assert reset at sendCount=3 -> next cycle io_out_valid=0, io_in_ready=1. A new flit then starts at beat 0.
- Change io_in_bits while sending (io_in_valid=1) -> no effect on emitted beats; that flit is accepted only after the frame ends.

Source files
------------

// File: rtl/generic_flit_pkg.sv
// Shared flit layout for the 32-bit generic flit link: field widths, frame
// offsets, the flit struct and the frame pack function used by both link ends.
package generic_flit_pkg;

  localparam int CHANID_W = 3;
  localparam int OPCODE_W = 3;
  localparam int PARAM_W  = 3;
  localparam int SIZE_W   = 8;
  localparam int SOURCE_W = 8;
  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int UNION_W  = 9;

  // Bit 0 of the frame is a reserved zero; fields follow from bit 1 upward.
  localparam int UNION_LSB   = 1;
  localparam int CORRUPT_LSB = 10;
  localparam int DATA_LSB    = 11;
  localparam int ADDR_LSB    = 75;
  localparam int SOURCE_LSB  = 139;
  localparam int SIZE_LSB    = 147;
  localparam int PARAM_LSB   = 155;
  localparam int OPCODE_LSB  = 158;
  localparam int CHANID_LSB  = 161;

  localparam int FLIT_BITS = 164;
  localparam int BEATS     = 6;
  localparam int BEAT_W    = 32;
  localparam int FRAME_W   = BEATS * BEAT_W;
  localparam int COUNT_W   = 3;

  localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(BEATS - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SENDING = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic [CHANID_W-1:0] chan_id;
    logic [OPCODE_W-1:0] opcode;
    logic [PARAM_W-1:0]  param;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
    logic [UNION_W-1:0]  mask_union;
  } generic_flit_t;

  function automatic logic [FRAME_W-1:0] pack_flit(input generic_flit_t f);
    logic [FRAME_W-1:0] frame;
    frame = '0;
    frame[UNION_LSB  +: UNION_W]  = f.mask_union;
    frame[CORRUPT_LSB]            = f.corrupt;
    frame[DATA_LSB   +: DATA_W]   = f.data;
    frame[ADDR_LSB   +: ADDR_W]   = f.address;
    frame[SOURCE_LSB +: SOURCE_W] = f.source;
    frame[SIZE_LSB   +: SIZE_W]   = f.size;
    frame[PARAM_LSB  +: PARAM_W]  = f.param;
    frame[OPCODE_LSB +: OPCODE_W] = f.opcode;
    frame[CHANID_LSB +: CHANID_W] = f.chan_id;
    return frame;
  endfunction

endpackage

// File: rtl/generic_serializer.sv
// Transmit side of the generic flit link: captures one flit and streams it as
// six 32-bit beats, lowest word first. GENERIC_SERIALIZER_BACK_TO_BACK_EN lets
// the next flit load in the same cycle the last beat fires.
module generic_serializer
  import generic_flit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [2:0]  io_in_bits_chanId,
  input  logic [2:0]  io_in_bits_opcode,
  input  logic [2:0]  io_in_bits_param,
  input  logic [7:0]  io_in_bits_size,
  input  logic [7:0]  io_in_bits_source,
  input  logic [63:0] io_in_bits_address,
  input  logic [63:0] io_in_bits_data,
  input  logic        io_in_bits_corrupt,
  input  logic [8:0]  io_in_bits_union,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_bits
);

  ser_state_t         state;
  logic [COUNT_W-1:0] send_count;
  logic [BEAT_W-1:0]  beat_q [BEATS];

  generic_flit_t      flit;
  logic [FRAME_W-1:0] frame;
  logic               sending;
  logic               last_beat;
  logic               in_fire;
  logic               out_fire;

  assign flit = '{
    chan_id:    io_in_bits_chanId,
    opcode:     io_in_bits_opcode,
    param:      io_in_bits_param,
    size:       io_in_bits_size,
    source:     io_in_bits_source,
    address:    io_in_bits_address,
    data:       io_in_bits_data,
    corrupt:    io_in_bits_corrupt,
    mask_union: io_in_bits_union
  };
  assign frame = pack_flit(flit);

  assign sending   = (state == ST_SENDING);
  assign last_beat = (send_count == LAST_BEAT);

`ifdef GENERIC_SERIALIZER_BACK_TO_BACK_EN
  assign io_in_ready = ~sending | (io_out_ready & last_beat);
`else
  assign io_in_ready = ~sending;
`endif

  // Output beat comes straight from the capture registers, never from io_in_bits.
  assign io_out_valid = sending;
  assign io_out_bits  = beat_q[send_count];

  assign in_fire  = io_in_valid & io_in_ready;
  assign out_fire = io_out_valid & io_out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      send_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            state      <= ST_SENDING;
            send_count <= '0;
          end
        end
        ST_SENDING: begin
          if (out_fire) begin
            if (last_beat) begin
              send_count <= '0;
              state      <= in_fire ? ST_SENDING : ST_IDLE;
            end else begin
              send_count <= send_count + COUNT_W'(1);
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          send_count <= '0;
        end
      endcase
    end
  end

  // NOTE: the beat registers are deliberately left out of reset; they are only
  // observed while sending, which always follows a fresh capture.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      for (int k = 0; k < BEATS; k++) begin
        beat_q[k] <= frame[k*BEAT_W +: BEAT_W];
      end
    end
  end

endmodule
